// File: rtl/multicycle_ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the multi-cycle RV32I sequencer.
//   - ALU operation codes driven on alu_sel
//   - opcode[6:2] values of the supported major opcodes
//   - FSM state encoding, decoded instruction class, wb_sel encodings
package ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLT    = 4'd2,
    ALU_SLTU   = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_OR     = 4'd5,
    ALU_AND    = 4'd6,
    ALU_SLL    = 4'd7,
    ALU_SRL    = 4'd8,
    ALU_SRA    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    CLS_ILLEGAL,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_BRANCH,
    CLS_LOAD,
    CLS_STORE,
    CLS_OPIMM,
    CLS_OP
  } cls_e;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  // alt picks SUB over ADD and SRA over SRL; callers decide when it applies.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: shared instruction/data memory port handshake.
//   mem_req      controller -> memory  request, held until ack or timeout
//   mem_is_fetch controller -> memory  address select: 1 = PC, 0 = ALU result
//   mem_wren     controller -> memory  store strobe, only with mem_req
//   mem_ack      memory -> controller  request completed this cycle
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_is_fetch;
  logic mem_wren;
  logic mem_ack;

  modport master (output mem_req, output mem_is_fetch, output mem_wren, input mem_ack);
  modport slave  (input mem_req, input mem_is_fetch, input mem_wren, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// mc_decode: combinational instruction classifier.
//   instr        IR contents
//   br_less      comparator rs1 < rs2
//   br_equal     comparator rs1 == rs2
//   cls          instruction class (CLS_ILLEGAL for unsupported opcode/funct3)
//   legal        cls is not CLS_ILLEGAL
//   alu_op       ALU operation for the instruction
//   op_a_pc      ALU operand A = PC
//   op_b_imm     ALU operand B = immediate
//   br_unsigned  unsigned branch compare
//   br_taken     branch condition holds
module mc_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        br_less,
  input  logic        br_equal,
  output cls_e        cls,
  output logic        legal,
  output alu_op_e     alu_op,
  output logic        op_a_pc,
  output logic        op_b_imm,
  output logic        br_unsigned,
  output logic        br_taken
);

  logic [2:0] funct3;
  logic       alt;
  logic       unused_instr_bits;

  assign funct3 = instr[14:12];
  assign alt    = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    cls = CLS_ILLEGAL;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:2])
        OPC_LUI:    cls = CLS_LUI;
        OPC_AUIPC:  cls = CLS_AUIPC;
        OPC_JAL:    cls = CLS_JAL;
        OPC_JALR:   cls = CLS_JALR;
        OPC_BRANCH: if (funct3[2:1] != 2'b01) cls = CLS_BRANCH;
        OPC_LOAD:   if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) cls = CLS_LOAD;
        OPC_STORE:  if (funct3 inside {3'b000, 3'b001, 3'b010}) cls = CLS_STORE;
        OPC_OPIMM:  cls = CLS_OPIMM;
        OPC_OP:     cls = CLS_OP;
        default:    cls = CLS_ILLEGAL;
      endcase
    end
  end

  assign legal = (cls != CLS_ILLEGAL);

  always_comb begin
    alu_op   = ALU_ADD;
    op_a_pc  = 1'b0;
    op_b_imm = 1'b0;
    case (cls)
      CLS_BRANCH, CLS_JAL, CLS_AUIPC: begin
        op_a_pc  = 1'b1;
        op_b_imm = 1'b1;
      end
      CLS_JALR, CLS_LOAD, CLS_STORE: op_b_imm = 1'b1;
      CLS_LUI: begin
        op_b_imm = 1'b1;
        alu_op   = ALU_PASS_B;
      end
      // instr[30] is part of a signed immediate for addi etc., so only SRAI looks at it
      CLS_OPIMM: begin
        op_b_imm = 1'b1;
        alu_op   = alu_from_funct3(funct3, alt && (funct3 == 3'b101));
      end
      CLS_OP:  alu_op = alu_from_funct3(funct3, alt);
      default: ;
    endcase
  end

  assign br_unsigned = funct3[1];

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:         br_taken = br_equal;
      3'b001:         br_taken = !br_equal;
      3'b100, 3'b110: br_taken = br_less;
      3'b101, 3'b111: br_taken = !br_less;
      default:        br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I datapath
// sharing one memory port for instructions and data.
//   clk, rst          clock, asynchronous active-high reset
//   instr             IR contents (valid from DECODE)
//   br_less/br_equal  branch comparator results
//   mem               memory handshake (master side)
//   ir_wren, pc_wren, pc_sel, br_unsigned, rd_wren, op_a_sel, op_b_sel,
//   alu_sel, wb_sel   datapath controls
//   retire, illegal, bus_err  one-cycle status pulses
//
// state  | meaning
// FETCH  | request instruction at PC, load IR on ack
// DECODE | classify IR; illegal skips to next PC
// EXEC   | branches resolve and retire; load/store form address
// MEM    | data access at ALU result
// WB     | register write, PC update, retire
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TO_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               instr,
  input  logic                      br_less,
  input  logic                      br_equal,
  multicycle_ctrl_if.master         mem,
  output logic                      ir_wren,
  output logic                      pc_wren,
  output logic                      pc_sel,
  output logic                      br_unsigned,
  output logic                      rd_wren,
  output logic                      op_a_sel,
  output logic                      op_b_sel,
  output logic [3:0]                alu_sel,
  output logic [1:0]                wb_sel,
  output logic                      retire,
  output logic                      illegal,
  output logic                      bus_err
);

  localparam logic [TO_W-1:0] WAIT_MAX = '1;

  state_e          state, state_next;
  logic [TO_W-1:0] wait_cnt;
  logic            req_state;
  logic            timeout;

  cls_e    dec_cls;
  logic    dec_legal;
  alu_op_e dec_alu;
  logic    dec_a_pc;
  logic    dec_b_imm;
  logic    dec_bru;
  logic    dec_taken;

  mc_decode u_decode (
    .instr      (instr),
    .br_less    (br_less),
    .br_equal   (br_equal),
    .cls        (dec_cls),
    .legal      (dec_legal),
    .alu_op     (dec_alu),
    .op_a_pc    (dec_a_pc),
    .op_b_imm   (dec_b_imm),
    .br_unsigned(dec_bru),
    .br_taken   (dec_taken)
  );

  assign req_state = (state == ST_FETCH) || (state == ST_MEM);
  // In the timeout cycle the request is withdrawn; a late ack is still honoured.
  assign timeout   = req_state && (wait_cnt == WAIT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (req_state && !mem.mem_ack && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                                       wait_cnt <= '0;
    end
  end

  always_comb begin
    state_next       = state;
    mem.mem_req      = 1'b0;
    mem.mem_is_fetch = 1'b0;
    mem.mem_wren     = 1'b0;
    ir_wren          = 1'b0;
    pc_wren          = 1'b0;
    pc_sel           = 1'b0;
    br_unsigned      = 1'b0;
    rd_wren          = 1'b0;
    op_a_sel         = 1'b0;
    op_b_sel         = 1'b0;
    alu_sel          = ALU_ADD;
    wb_sel           = WB_ALU;
    retire           = 1'b0;
    illegal          = 1'b0;
    bus_err          = 1'b0;

    if (!rst) begin
      // ALU operands stay stable from EXEC until the instruction completes.
      if (state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
        op_a_sel = dec_a_pc;
        op_b_sel = dec_b_imm;
        alu_sel  = dec_alu;
      end

      case (state)
        ST_FETCH: begin
          mem.mem_is_fetch = 1'b1;
          mem.mem_req      = !timeout;
          if (mem.mem_ack) begin
            ir_wren    = 1'b1;
            state_next = ST_DECODE;
          end else if (timeout) begin
            bus_err    = 1'b1;
            state_next = ST_FETCH;
          end
        end

        ST_DECODE: begin
          if (!dec_legal) begin
            illegal    = 1'b1;
            pc_wren    = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_EXEC;
          end
        end

        ST_EXEC: begin
          case (dec_cls)
            CLS_BRANCH: begin
              br_unsigned = dec_bru;
              pc_wren     = 1'b1;
              pc_sel      = dec_taken;
              retire      = 1'b1;
              state_next  = ST_FETCH;
            end
            CLS_LOAD, CLS_STORE: state_next = ST_MEM;
            default:             state_next = ST_WB;
          endcase
        end

        ST_MEM: begin
          mem.mem_req  = !timeout;
          mem.mem_wren = (dec_cls == CLS_STORE) && !timeout;
          if (mem.mem_ack) begin
            if (dec_cls == CLS_STORE) begin
              pc_wren    = 1'b1;
              retire     = 1'b1;
              state_next = ST_FETCH;
            end else begin
              state_next = ST_WB;
            end
          end else if (timeout) begin
            bus_err    = 1'b1;
            pc_wren    = 1'b1;
            state_next = ST_FETCH;
          end
        end

        ST_WB: begin
          rd_wren    = 1'b1;
          pc_wren    = 1'b1;
          retire     = 1'b1;
          state_next = ST_FETCH;
          if (dec_cls == CLS_LOAD) begin
            wb_sel = WB_LOAD;
          end else if (dec_cls == CLS_JAL || dec_cls == CLS_JALR) begin
            wb_sel = WB_PC4;
            pc_sel = 1'b1;
          end
        end

        default: state_next = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed vectors for multicycle_ctrl. Each instruction is
// run from FETCH until its retire/illegal/bus_err pulse; the memory model acks
// after a programmed number of wait cycles. Outputs are sampled 1 time unit
// after the falling edge.
module tb_multicycle_ctrl;

  localparam int TO_W = 4;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        br_less;
  logic        br_equal;
  logic        ir_wren, pc_wren, pc_sel, br_unsigned, rd_wren;
  logic        op_a_sel, op_b_sel, retire, illegal, bus_err;
  logic [3:0]  alu_sel;
  logic [1:0]  wb_sel;
  logic [18:0] all_outs;

  int n_tests = 0;
  int n_fail  = 0;

  int          r_cyc, r_rd, r_mreq, r_mwr, r_pc, r_be;
  logic [18:0] r_last;

  multicycle_ctrl_if mem_bus ();

  multicycle_ctrl #(.TO_W(TO_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .br_less    (br_less),
    .br_equal   (br_equal),
    .mem        (mem_bus),
    .ir_wren    (ir_wren),
    .pc_wren    (pc_wren),
    .pc_sel     (pc_sel),
    .br_unsigned(br_unsigned),
    .rd_wren    (rd_wren),
    .op_a_sel   (op_a_sel),
    .op_b_sel   (op_b_sel),
    .alu_sel    (alu_sel),
    .wb_sel     (wb_sel),
    .retire     (retire),
    .illegal    (illegal),
    .bus_err    (bus_err)
  );

  assign all_outs = {mem_bus.mem_req, mem_bus.mem_is_fetch, mem_bus.mem_wren, ir_wren,
                     pc_wren, pc_sel, br_unsigned, rd_wren, op_a_sel, op_b_sel,
                     alu_sel, wb_sel, retire, illegal, bus_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] pack(input logic req, isf, mwr, irw, pcw, pcs, bru, rdw,
                                       input logic opa, opb, input logic [3:0] alu,
                                       input logic [1:0] wb, input logic ret, ill, be);
    return {req, isf, mwr, irw, pcw, pcs, bru, rdw, opa, opb, alu, wb, ret, ill, be};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one instruction from FETCH; fw/mw = wait cycles before ack in fetch/mem.
  task automatic run(input string tag, input logic [31:0] ins, input int fw, input int mw,
                     input logic beq, input logic blt);
    int   wcnt = 0;
    bit   done = 0;
    logic prev_req = 1'b0;
    logic ack;
    instr    = ins;
    br_equal = beq;
    br_less  = blt;
    r_cyc = 0; r_rd = 0; r_mreq = 0; r_mwr = 0; r_pc = 0; r_be = 0; r_last = '0;
    while (!done && r_cyc < 64) begin
      ack = 1'b0;
      if (mem_bus.mem_req || prev_req) begin
        if (wcnt == (mem_bus.mem_is_fetch ? fw : mw)) begin
          ack  = 1'b1;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      prev_req = mem_bus.mem_req && !ack;
      mem_bus.mem_ack = ack;
      #1;
      r_cyc++;
      r_rd  += int'(rd_wren);
      r_mwr += int'(mem_bus.mem_wren);
      r_pc  += int'(pc_wren);
      r_be  += int'(bus_err);
      if (mem_bus.mem_req && !mem_bus.mem_is_fetch) r_mreq++;
      r_last = all_outs;
      if (retire || illegal || bus_err) done = 1;
      @(negedge clk);
      mem_bus.mem_ack = 1'b0;
      #1;
    end
    check({tag, "_completes"}, 32'(done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; instr = '0; br_less = 1'b0; br_equal = 1'b0; mem_bus.mem_ack = 1'b0;

    // Reset state
    @(negedge clk); #1;
    check("reset_outs", 32'(all_outs), 32'd0);
    @(negedge clk);
    rst = 1'b0; #1;
    check("first_fetch", {29'd0, mem_bus.mem_req, mem_bus.mem_is_fetch, pc_wren}, 32'b110);

    // Reset asserted mid-MEM with ack high
    instr = 32'h0000A103;
    mem_bus.mem_ack = 1'b1; #1;
    check("rst_seq_irw", 32'(ir_wren), 32'd1);
    @(negedge clk); mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("rst_seq_in_mem", {30'd0, mem_bus.mem_req, mem_bus.mem_is_fetch}, 32'b10);
    mem_bus.mem_ack = 1'b1; rst = 1'b1; #1;
    check("rst_mid_mem_outs", 32'(all_outs), 32'd0);
    @(negedge clk); #1;
    check("rst_hold_outs", 32'(all_outs), 32'd0);
    rst = 1'b0; mem_bus.mem_ack = 1'b0; #1;
    check("rst_release_fetch", {29'd0, mem_bus.mem_req, mem_bus.mem_is_fetch, pc_wren}, 32'b110);

    // addi x1,x0,5
    run("addi", 32'h00500093, 0, 0, 1'b0, 1'b0);
    check("addi_cycles", r_cyc, 4);
    check("addi_rd_count", r_rd, 1);
    check("addi_wb", 32'(r_last), 32'(pack(0,0,0,0,1,0,0,1,0,1,4'd0,2'd0,1,0,0)));
    check("addi_next_fetch", {30'd0, mem_bus.mem_req, mem_bus.mem_is_fetch}, 32'b11);

    // lw x2,0(x1), three data wait cycles
    run("lw", 32'h0000A103, 0, 3, 1'b0, 1'b0);
    check("lw_cycles", r_cyc, 8);
    check("lw_mem_req", r_mreq, 4);
    check("lw_mem_wren", r_mwr, 0);
    check("lw_wb", 32'(r_last), 32'(pack(0,0,0,0,1,0,0,1,0,1,4'd0,2'd1,1,0,0)));

    // bne x1,x2,+8 taken / not taken
    run("bne_t", 32'h00209463, 0, 0, 1'b0, 1'b0);
    check("bne_t_cycles", r_cyc, 3);
    check("bne_t_rd", r_rd, 0);
    check("bne_t_exec", 32'(r_last), 32'(pack(0,0,0,0,1,1,0,0,1,1,4'd0,2'd0,1,0,0)));
    run("bne_n", 32'h00209463, 0, 0, 1'b1, 1'b0);
    check("bne_n_cycles", r_cyc, 3);
    check("bne_n_rd", r_rd, 0);
    check("bne_n_exec", 32'(r_last), 32'(pack(0,0,0,0,1,0,0,0,1,1,4'd0,2'd0,1,0,0)));

    // bgeu x1,x2,+8 with rs1 < rs2: not taken, unsigned compare
    run("bgeu", 32'h0020F463, 0, 0, 1'b0, 1'b1);
    check("bgeu_exec", 32'(r_last), 32'(pack(0,0,0,0,1,0,1,0,1,1,4'd0,2'd0,1,0,0)));

    // sw x2,4(x1)
    run("sw", 32'h0020A223, 0, 0, 1'b0, 1'b0);
    check("sw_cycles", r_cyc, 4);
    check("sw_mem_wren", r_mwr, 1);
    check("sw_rd", r_rd, 0);
    check("sw_mem", 32'(r_last), 32'(pack(1,0,1,0,1,0,0,0,0,1,4'd0,2'd0,1,0,0)));

    // jal x1,+8 / sub x3,x1,x2 / srai x3,x1,2 / lui x5,0x12345
    run("jal", 32'h008000EF, 0, 0, 1'b0, 1'b0);
    check("jal_cycles", r_cyc, 4);
    check("jal_wb", 32'(r_last), 32'(pack(0,0,0,0,1,1,0,1,1,1,4'd0,2'd2,1,0,0)));
    run("sub", 32'h402081B3, 0, 0, 1'b0, 1'b0);
    check("sub_wb", 32'(r_last), 32'(pack(0,0,0,0,1,0,0,1,0,0,4'd1,2'd0,1,0,0)));
    run("srai", 32'h4020D193, 0, 0, 1'b0, 1'b0);
    check("srai_wb", 32'(r_last), 32'(pack(0,0,0,0,1,0,0,1,0,1,4'd9,2'd0,1,0,0)));
    run("lui", 32'h123452B7, 0, 0, 1'b0, 1'b0);
    check("lui_wb", 32'(r_last), 32'(pack(0,0,0,0,1,0,0,1,0,1,4'd10,2'd0,1,0,0)));

    // Fetch with no ack: 15 wait cycles, then bus_err with the request dropped
    run("fetch_to", 32'h00500093, 1000, 0, 1'b0, 1'b0);
    check("fetch_to_cycles", r_cyc, 16);
    check("fetch_to_pc", r_pc, 0);
    check("fetch_to_last", 32'(r_last), 32'(pack(0,1,0,0,0,0,0,0,0,0,4'd0,2'd0,0,0,1)));
    check("fetch_to_retry", {30'd0, mem_bus.mem_req, mem_bus.mem_is_fetch}, 32'b11);

    // Ack arriving in the timeout cycle is accepted
    run("late_ack", 32'h00500093, 15, 0, 1'b0, 1'b0);
    check("late_ack_cycles", r_cyc, 19);
    check("late_ack_be", r_be, 0);
    check("late_ack_rd", r_rd, 1);

    // Illegal opcode and illegal load funct3
    run("ill_op", 32'hFFFFFFFF, 0, 0, 1'b0, 1'b0);
    check("ill_op_cycles", r_cyc, 2);
    check("ill_op_rd_mwr", r_rd + r_mwr, 0);
    check("ill_op_dec", 32'(r_last), 32'(pack(0,0,0,0,1,0,0,0,0,0,4'd0,2'd0,0,1,0)));
    check("ill_op_next_fetch", {30'd0, mem_bus.mem_req, mem_bus.mem_is_fetch}, 32'b11);
    run("ill_ld", 32'h0000B103, 0, 0, 1'b0, 1'b0);
    check("ill_ld_cycles", r_cyc, 2);
    check("ill_ld_dec", 32'(r_last), 32'(pack(0,0,0,0,1,0,0,0,0,0,4'd0,2'd0,0,1,0)));

    // Load whose data access never completes: dropped after timeout
    run("mem_to", 32'h0000A103, 0, 1000, 1'b0, 1'b0);
    check("mem_to_cycles", r_cyc, 19);
    check("mem_to_req", r_mreq, 15);
    check("mem_to_rd", r_rd, 0);
    check("mem_to_last", 32'(r_last), 32'(pack(0,0,0,0,1,0,0,0,0,1,4'd0,2'd0,0,0,1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
